// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and decoder FSM state encoding.
package vga_timing_pkg;

    localparam int unsigned VGA_H_TOTAL  = 800;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_H_START  = VGA_H_SYNC + VGA_H_BACK;

    localparam int unsigned VGA_V_TOTAL  = 521;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 29;
    localparam int unsigned VGA_V_START  = VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned VGA_LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } vga_sync_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an active-low sync plus a falling-edge detect
// qualified by the pixel strobe.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pix_en,
    input  logic i_sync_n,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer runs every clock; idles high like an undriven sync.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_sync_n;
            r_sync <= r_meta;
        end
    end

    // Previous value advances only on pixel strobes so edges stay pixel-aligned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b1;
        end else if (i_pix_en) begin
            r_prev <= r_sync;
        end
    end

    assign o_fall = i_pix_en & r_prev & ~r_sync;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers pixel coordinates, checks line and
// frame lengths, and tracks lock over consecutive clean frames.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned H_START     = VGA_H_START,
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned V_START     = VGA_V_START,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pix_en_i,
    input  logic       h_sync_i,
    input  logic       v_sync_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       active_o,
    output logic       locked_o,
    output logic       frame_start_o,
    output logic       line_err_o,
    output logic       frame_err_o
);

    localparam logic [9:0] C_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_H_START = 10'(H_START);
    localparam logic [9:0] C_H_END   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] C_V_START = 10'(V_START);
    localparam logic [9:0] C_V_END   = 10'(V_START + V_ACTIVE);
    localparam logic [2:0] C_LOCK    = 3'(LOCK_FRAMES);

    logic            w_h_fall;
    logic            w_v_fall;
    logic [9:0]      r_h_cnt;
    logic [9:0]      r_v_cnt;
    logic            w_line_bad;
    logic            w_frame_bad;
    logic            w_checking;
    vga_sync_state_e r_state;
    vga_sync_state_e w_state_nxt;
    logic [2:0]      r_good;
    logic [2:0]      w_good_nxt;
    logic [2:0]      w_good_inc;
    logic            w_h_vis;
    logic            w_v_vis;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic            r_active;
    logic            r_locked;
    logic            r_frame_start;
    logic            r_line_err;
    logic            r_frame_err;

    sync_edge_detect u_h_edge (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_pix_en (pix_en_i),
        .i_sync_n (h_sync_i),
        .o_fall   (w_h_fall)
    );

    sync_edge_detect u_v_edge (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_pix_en (pix_en_i),
        .i_sync_n (v_sync_i),
        .o_fall   (w_v_fall)
    );

    // Pixel and line counters; both saturate so a lost sync cannot wrap them.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_en_i) begin
            if (w_h_fall) begin
                r_h_cnt <= '0;
            end else if (r_h_cnt != '1) begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
            if (w_v_fall) begin
                r_v_cnt <= '0;
            end else if (w_h_fall && (r_v_cnt != '1)) begin
                r_v_cnt <= r_v_cnt + 10'd1;
            end
        end
    end

    // Length checks: a sync at the wrong count, or the count running past the end.
    always_comb begin
        w_line_bad  = 1'b0;
        w_frame_bad = 1'b0;
        if (pix_en_i) begin
            if (w_h_fall) begin
                w_line_bad = (r_h_cnt != C_H_LAST);
            end else begin
                w_line_bad = (r_h_cnt == C_H_LAST);
            end
            if (w_v_fall) begin
                w_frame_bad = (r_v_cnt != C_V_LAST);
            end else if (w_h_fall) begin
                w_frame_bad = (r_v_cnt == C_V_LAST);
            end
        end
    end

    assign w_checking = (r_state != ST_SEARCH);
    assign w_good_inc = r_good + 3'd1;

    // Lock FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_SEARCH;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    // Lock FSM next state: any error drops back to search once checking has begun.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            ST_SEARCH: begin
                if (w_v_fall) begin
                    w_state_nxt = ST_MEASURE;
                    w_good_nxt  = '0;
                end
            end
            ST_MEASURE: begin
                if (w_line_bad || w_frame_bad) begin
                    w_state_nxt = ST_SEARCH;
                end else if (w_v_fall) begin
                    w_good_nxt = w_good_inc;
                    if (w_good_inc == C_LOCK) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_line_bad || w_frame_bad) begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    assign w_h_vis = (r_h_cnt >= C_H_START) && (r_h_cnt < C_H_END);
    assign w_v_vis = (r_v_cnt >= C_V_START) && (r_v_cnt < C_V_END);

    // Registered outputs: coordinates follow the counters, pulses follow detection.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_err    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_locked      <= (w_state_nxt == ST_LOCKED);
            r_frame_start <= w_v_fall;
            r_line_err    <= w_line_bad & w_checking;
            r_frame_err   <= w_frame_bad & w_checking;
            if ((r_state == ST_LOCKED) && w_h_vis && w_v_vis) begin
                r_active <= 1'b1;
                r_x      <= r_h_cnt - C_H_START;
                r_y      <= r_v_cnt - C_V_START;
            end else begin
                r_active <= 1'b0;
                r_x      <= '0;
                r_y      <= '0;
            end
        end
    end

    assign x_o           = r_x;
    assign y_o           = r_y;
    assign active_o      = r_active;
    assign locked_o      = r_locked;
    assign frame_start_o = r_frame_start;
    assign line_err_o    = r_line_err;
    assign frame_err_o   = r_frame_err;

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator: consumes the active-low `h_sync`/`v_sync` pair and the 25 MHz pixel-enable strobe, recovers pixel coordinates and the active-video flag, and checks line and frame lengths against 640x480@60 timing. It sits on the capture/loopback path and in the verification harness. It reports lock status and one-shot error pulses.

## Interface
- `H_TOTAL`, 800: pixels per line.
- `H_START`, 144: `h_cnt` of first visible pixel (sync 96 + back porch 48).
- `H_ACTIVE`, 640: visible pixels per line.
- `V_TOTAL`, 521: lines per frame.
- `V_START`, 31: `v_cnt` of first visible line (sync 2 + back porch 29).
- `V_ACTIVE`, 480: visible lines.
- `LOCK_FRAMES`, 2: consecutive clean frames required for lock (1..7).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `pix_en_i`  in  1  one-clk pixel strobe (25 MHz); all counting happens only on these cycles.
- `h_sync_i`  in  1  horizontal sync, active-low, asynchronous to `clk_i`.
- `v_sync_i`  in  1  vertical sync, active-low, asynchronous to `clk_i`.
- `x_o`  out  10  pixel column 0..639 while `active_o`, else 0.
- `y_o`  out  10  pixel row 0..479 while `active_o`, else 0.
- `active_o`  out  1  visible pixel and decoder locked.
- `locked_o`  out  1  timing locked.
- `frame_start_o`  out  1  one-clk pulse on every accepted `v_sync` falling edge.
- `line_err_o`  out  1  one-clk pulse on a bad line length (MEASURE/LOCKED only).
- `frame_err_o`  out  1  one-clk pulse on a bad frame length (MEASURE/LOCKED only).

## Operation
- Both syncs pass through a 2-flop synchronizer clocked every `clk_i`. A previous-value register updates only on `pix_en_i`. A fall is `prev=1 & cur=0` on a `pix_en_i` cycle.
- `h_cnt` (10 b): set to 0 on an h-fall, else +1 per `pix_en_i`, saturating at 1023.
- `v_cnt` (10 b): set to 0 on a v-fall. Otherwise it increments on each h-fall, saturating at 1023.
- A v-fall and an h-fall in the same cycle give `v_cnt`=0; v-fall has priority.
- Line check: on an h-fall, the old `h_cnt` must equal `H_TOTAL-1`. If `h_cnt` reaches `H_TOTAL` with no h-fall, that is also a line error (missing sync).
- Frame check: on a v-fall, the old `v_cnt` must equal `V_TOTAL-1`. If `v_cnt` reaches `V_TOTAL` with no v-fall, that is also a frame error.
- FSM states: SEARCH, MEASURE, LOCKED; a 3-bit `good` counter tracks clean frames.
  - SEARCH → MEASURE on the first v-fall; `good`=0.
  - MEASURE: each v-fall with no error since the previous v-fall increments `good`. Go to LOCKED when `good` reaches `LOCK_FRAMES`.
  - MEASURE/LOCKED → SEARCH on any line or frame error; the error pulse still fires.
  - Errors in SEARCH are neither reported nor acted on.
- Outputs in LOCKED:
  - `active_o` = (`H_START` ≤ `h_cnt` < `H_START+H_ACTIVE`) & (`V_START` ≤ `v_cnt` < `V_START+V_ACTIVE`).
  - `x_o` = `h_cnt-H_START`; `y_o` = `v_cnt-V_START`.
- Outside LOCKED: `active_o`, `x_o`, `y_o` are all 0.
- `frame_start_o` pulses on every v-fall in any state.

## Timing
- Reset values: all outputs 0, FSM=SEARCH, `h_cnt`=`v_cnt`=0, synchronizer and `prev` registers = 1 (idle-high).
- Input latency: a sync edge becomes visible on the first `pix_en_i` cycle at least 2 clks after the edge.
- Coordinate outputs and `active_o` are registered from the counter values. They update one clk after the `pix_en_i` cycle that advanced the counters and hold between strobes.
- `locked_o` rises one clk after the qualifying v-fall. `frame_start_o` and the error pulses are one clk after their detecting cycle, for one clk only.
- `pix_en_i` low freezes all counters and state; the synchronizers keep running.
- Reset asserted mid-frame: everything returns to reset values immediately (async). After release, lock needs 1 + `LOCK_FRAMES` v-falls again.

## Structure
- Package `vga_timing_pkg`: the 640x480@60 constants (800/640/16/96/48 and 521/480/10/2/29) and the FSM state encoding. The VGA generator shares this package.
- Sub-module `sync_edge_detect` (2-flop synchronizer + `pix_en`-qualified fall detect), instantiated once per sync.
- Top level holds the counters, checks, FSM and output registers.

## Test plan
- Reset, then ideal 640x480 stream (reset with `rst_i`=0). `frame_start_o` pulses on every v-fall. `locked_o` rises after the 3rd v-fall, with 0 error pulses.
- Locked, first visible pixel (`h_cnt`=144, `v_cnt`=31) → `active_o`=1, `x_o`=0, `y_o`=0. At `h_cnt`=783, `v_cnt`=510 → `x_o`=639, `y_o`=479. At `h_cnt`=784 → `active_o`=0, `x_o`=0.
- Locked, one line shortened to 799 pixels → one `line_err_o` pulse, `locked_o`=0, `active_o`=0; relock after 3 further v-falls.
- Locked, v_sync suppressed → `frame_err_o` pulse when `v_cnt` hits 521, state SEARCH. Pulse on an h-fall/v-fall coincidence → `v_cnt`=0.
- `pix_en_i` held low for 50 clks mid-line → `x_o`/`h_cnt` unchanged, then resumes +1 per strobe.
- `rst_i` pulled low mid-frame for 3 clks → all outputs 0 immediately; no errors reported until MEASURE is re-entered.
